// File: rtl/alu_seq_pp44.sv
// Command sequencer driving an external 8-bit ALU from a 4x8 register file.
// Build option: define ALU_SEQ_CHAIN_EN to feed flag_c back as the ALU carry-in.
module alu_seq_pp44 (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_pass,
  input  logic [1:0] cmd_dst,
  input  logic [1:0] cmd_srca,
  input  logic [1:0] cmd_srcb,
  input  logic       cmd_bsel,
  input  logic [7:0] cmd_imm,
  input  logic       cmd_cin,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_en,
  output logic       alu_cin,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_z,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

  state_e     state_q, state_d;
  logic [7:0] rf_q [4];
  logic [1:0] dst_q;
  logic [7:0] alu_a_q, alu_b_q, result_q;
  logic [2:0] alu_op_q;
  logic       alu_en_q, alu_cin_q, flag_c_q, flag_z_q;
  logic       accept;
  logic       cin_sel;

`ifdef ALU_SEQ_CHAIN_EN
  logic unused_cmd_cin;
  assign unused_cmd_cin = cmd_cin;
  assign cin_sel = flag_c_q;
`else
  assign cin_sel = cmd_cin;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) state_d = StIssue;
      end
      StIssue: begin
        cmd_ready = 1'b0;
        state_d   = StWb;
      end
      StWb: begin
        done    = 1'b1;
        state_d = cmd_valid ? StIssue : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dst_q     <= 2'd0;
      alu_a_q   <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_op_q  <= 3'd0;
      alu_en_q  <= 1'b0;
      alu_cin_q <= 1'b0;
      result_q  <= 8'h00;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      // Register file is written before WB, so a WB-cycle accept reads fresh data.
      if (accept) begin
        alu_a_q   <= rf_q[cmd_srca];
        alu_b_q   <= cmd_bsel ? cmd_imm : rf_q[cmd_srcb];
        alu_op_q  <= cmd_op;
        alu_en_q  <= !cmd_pass;
        alu_cin_q <= cin_sel;
        dst_q     <= cmd_dst;
      end
      if (state_q == StIssue) begin
        rf_q[dst_q] <= alu_res;
        result_q    <= alu_res;
        flag_z_q    <= (alu_res == 8'h00);
        // Carry-out is only meaningful for an enabled add-with-carry.
        if (alu_op_q == 3'b001 && alu_en_q) flag_c_q <= alu_cout;
      end
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign alu_en  = alu_en_q;
  assign alu_cin = alu_cin_q;
  assign result  = result_q;
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
  assign rd_data = rf_q[rd_sel];

endmodule

// File: tb/tb_alu_seq_pp44.sv
// Randomised self-checking bench for alu_seq_pp44 with a behavioural ALU and sequencer model.
module tb_alu_seq_pp44;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_pass;
  logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
  logic       cmd_bsel;
  logic [7:0] cmd_imm;
  logic       cmd_cin;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic       alu_en, alu_cin;
  logic [7:0] alu_res;
  logic       alu_cout;
  logic       done;
  logic [7:0] result;
  logic       flag_c, flag_z;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_regs [4];
  logic       exp_c, exp_z;
  logic [7:0] exp_res;

  alu_seq_pp44 dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_pass  (cmd_pass),
    .cmd_dst   (cmd_dst),
    .cmd_srca  (cmd_srca),
    .cmd_srcb  (cmd_srcb),
    .cmd_bsel  (cmd_bsel),
    .cmd_imm   (cmd_imm),
    .cmd_cin   (cmd_cin),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_en    (alu_en),
    .alu_cin   (alu_cin),
    .alu_res   (alu_res),
    .alu_cout  (alu_cout),
    .done      (done),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // ALU: {cout, res}. Outside enabled op 001 the carry is deliberately junk.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic en, input logic cin);
    int s, r;
    s = int'(a) + int'(b) + int'(cin);
    if (!en) r = int'(a);
    else begin
      case (op)
        3'd0: r = int'(a) + int'(b);
        3'd1: r = s;
        3'd2: r = int'(a) - int'(b);
        3'd3: r = int'(a) * int'(b);
        3'd4: r = int'(a & b);
        3'd5: r = int'(a | b);
        3'd6: r = int'(~a);
        default: r = int'(a ^ b);
      endcase
    end
    if (op == 3'd1 && en) return {(s <= 128), r[7:0]};
    return {(s > 128), r[7:0]};
  endfunction

  assign {alu_cout, alu_res} = alu_fn(alu_a, alu_b, alu_op, alu_en, alu_cin);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_regs[i] = 8'h00;
    exp_c   = 1'b0;
    exp_z   = 1'b0;
    exp_res = 8'h00;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      check_eq($sformatf("%s_reg%0d", tag, i), rd_data, exp_regs[i]);
    end
  endtask

  task automatic scramble_cmd();
    cmd_op   = 3'($urandom);
    cmd_pass = 1'($urandom);
    cmd_dst  = 2'($urandom);
    cmd_srca = 2'($urandom);
    cmd_srcb = 2'($urandom);
    cmd_bsel = 1'($urandom);
    cmd_imm  = 8'($urandom);
    cmd_cin  = 1'($urandom);
  endtask

  // Called at least 1 time unit after a rising edge, with the DUT in IDLE or WB.
  task automatic send(input logic [2:0] op, input logic pass, input logic [1:0] dst,
                      input logic [1:0] srca, input logic [1:0] srcb, input logic bsel,
                      input logic [7:0] imm, input logic cin);
    logic [7:0] ea, eb;
    logic       ecin;
    logic [8:0] r;
    cmd_op = op; cmd_pass = pass; cmd_dst = dst; cmd_srca = srca; cmd_srcb = srcb;
    cmd_bsel = bsel; cmd_imm = imm; cmd_cin = cin; cmd_valid = 1'b1;
    #1;
    check_eq("ready_accept", cmd_ready, 1'b1);
    ea = exp_regs[srca];
    eb = bsel ? imm : exp_regs[srcb];
`ifdef ALU_SEQ_CHAIN_EN
    ecin = exp_c;
`else
    ecin = cin;
`endif
    @(posedge clk); #1;
    // Garbage during ISSUE must be ignored.
    scramble_cmd();
    cmd_valid = 1'($urandom);
    check_eq("issue_ready", cmd_ready, 1'b0);
    check_eq("issue_done", done, 1'b0);
    check_eq("alu_a", alu_a, ea);
    check_eq("alu_b", alu_b, eb);
    check_eq("alu_op", alu_op, op);
    check_eq("alu_en", alu_en, !pass);
    check_eq("alu_cin", alu_cin, ecin);
    r = alu_fn(ea, eb, op, !pass, ecin);
    exp_regs[dst] = r[7:0];
    exp_res       = r[7:0];
    exp_z         = (r[7:0] == 8'h00);
    if (op == 3'd1 && !pass) exp_c = r[8];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("wb_done", done, 1'b1);
    check_eq("wb_ready", cmd_ready, 1'b1);
    check_eq("result", result, exp_res);
    check_eq("flag_z", flag_z, exp_z);
    check_eq("flag_c", flag_c, exp_c);
    check_regs("wb");
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check_eq("idle_done", done, 1'b0);
      check_eq("idle_ready", cmd_ready, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    rd_sel = 2'd0;
    scramble_cmd();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_ready", cmd_ready, 1'b1);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_alu_a", alu_a, 8'h00);
    check_eq("rst_alu_b", alu_b, 8'h00);
    check_eq("rst_alu_op", alu_op, 3'd0);
    check_eq("rst_alu_en", alu_en, 1'b0);
    check_eq("rst_alu_cin", alu_cin, 1'b0);
    check_eq("rst_result", result, 8'h00);
    check_eq("rst_flag_c", flag_c, 1'b0);
    check_eq("rst_flag_z", flag_z, 1'b0);
    check_regs("rst");

    // Directed sequence.
    send(3'd0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 1'b0);
    idle(1);
    send(3'd7, 1'b0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h05, 1'b0);
    idle(1);
    send(3'd0, 1'b0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h03, 1'b0);
    send(3'd1, 1'b0, 2'd3, 2'd1, 2'd0, 1'b1, 8'h00, 1'b0);
    check_eq("chain_flag_c", flag_c, 1'b1);
    check_eq("chain_reg3", exp_regs[3], 8'h08);
    send(3'd1, 1'b0, 2'd3, 2'd3, 2'd0, 1'b1, 8'h00, 1'b1);
    idle(1);
    send(3'd3, 1'b1, 2'd0, 2'd2, 2'd0, 1'b0, 8'h00, 1'b0);
    idle(2);

    // Reset in the middle of ISSUE abandons the command.
    cmd_op = 3'd0; cmd_pass = 1'b0; cmd_dst = 2'd1; cmd_srca = 2'd0; cmd_srcb = 2'd0;
    cmd_bsel = 1'b1; cmd_imm = 8'hFF; cmd_cin = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_ready", cmd_ready, 1'b1);
    check_eq("mid_rst_result", result, 8'h00);
    check_regs("mid_rst");
    idle(2);

    // Random commands, mixing back-to-back and idle gaps.
    for (int k = 0; k < 80; k++) begin
      send(3'($urandom), ($urandom_range(0, 4) == 0), 2'($urandom), 2'($urandom),
           2'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_pp44.md
# alu_seq_pp44

Command-driven sequencer that is the initiator side of the 8-bit ALU interface in the CPU datapath. It accepts one command at a time over a valid/ready handshake and reads operands from a 4×8 register file or an immediate. It drives the ALU operand, op, enable and carry-in lines from registers, then captures the ALU result and carry into the register file and the C/Z flags. It is the block that actually exercises the ALU in the CPU; the decoder talks to it, never to the ALU directly.

## Interface
- No parameters; data width fixed at 8, register file fixed at 4 entries.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  3  ALU op code passed to the ALU: 000 add, 001 add-with-carry, 010 sub, 011 mul (low byte), 100 and, 101 or, 110 not A, 111 xor.
- `cmd_pass`  in  1  1 = drive ALU enable low (result = A, register move).
- `cmd_dst`, `cmd_srca`, `cmd_srcb`  in  2 each  register indices.
- `cmd_bsel`  in  1  1 = B operand from `cmd_imm`, 0 = from `cmd_srcb`.
- `cmd_imm`  in  8  immediate operand.
- `cmd_cin`  in  1  carry-in when chaining is compiled out.
- `alu_a`, `alu_b`  out  8 each  registered ALU operands.
- `alu_op`  out  3  registered ALU op.
- `alu_en`  out  1  registered ALU enable.
- `alu_cin`  out  1  registered ALU carry-in.
- `alu_res`  in  8  ALU result, combinational from `alu_*` outputs.
- `alu_cout`  in  1  ALU carry-out; defined only for op 001.
- `done`  out  1  one-cycle pulse per completed command.
- `result`  out  8  registered result of the last command.
- `flag_c`, `flag_z`  out  1 each  carry and zero flags.
- `rd_sel`  in  2  debug register read index.
- `rd_data`  out  8  combinational read of register `rd_sel`.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1; on `cmd_valid`, go to ISSUE.
  - ISSUE: `cmd_ready`=0; unconditionally go to WB.
  - WB: `cmd_ready`=1, `done`=1; on `cmd_valid`, go to ISSUE, else go to IDLE.
- On accept:
  - `alu_a` ← reg[srca]; `alu_b` ← bsel ? imm : reg[srcb].
  - `alu_op` ← cmd_op; `alu_en` ← !cmd_pass; `alu_cin` per Configuration.
  - The operand registers hold their values until the next accept.
- End of ISSUE:
  - reg[dst] ← `alu_res`; `result` ← `alu_res`; `flag_z` ← (`alu_res`==0).
  - `flag_c` ← `alu_cout` only when op==001 and !pass; otherwise `flag_c` holds.
- `flag_c` stores `alu_cout` exactly as the ALU reports it, with no polarity inversion. ALU convention: 1 when A+B+Cin ≤ 0x80, else 0.
- Operand read in WB sees the write made at the end of ISSUE, so back-to-back dependent commands need no stall.
- Reset values:
  - State IDLE; `cmd_ready`=1.
  - All registers, `alu_*` outputs, `result`, `flag_c`, `flag_z` and `done` = 0.
- Reset mid-command: the command is abandoned, no register write, `done` stays 0, `cmd_ready`=1 in the following cycle.

## Timing
- Accept at edge E0 → ISSUE during E0–E1 → write at E1 → WB (`done`=1, `result` valid) during E1–E2.
- Latency: 2 cycles from accept to `done`.
- Throughput: 1 command per 2 cycles when `cmd_valid` is held high.
- `cmd_*` are sampled only at the accept edge; changes at any other time are ignored.
- `rd_data` reflects a write in the cycle after the write edge.

## Configuration
- `ALU_SEQ_CHAIN_EN` defined: `alu_cin` ← `flag_c` at accept, so multi-byte add-with-carry chains need no external carry; `cmd_cin` is unused.
- `ALU_SEQ_CHAIN_EN` undefined: `alu_cin` ← `cmd_cin` at accept; `flag_c` is still updated and observable.

## Test plan
- Reset, then command add dst=1 srca=0 imm=0x05 bsel=1 → `done` 2 cycles after accept, reg1=0x05, `result`=0x05, `flag_z`=0, `flag_c`=0 (unchanged).
- xor dst=2 srca=1 imm=0x05 → reg2=0x00, `flag_z`=1.
- Back-to-back, `cmd_valid` held: add dst=1 srca=1 imm=0x03, then add-with-carry dst=3 srca=1 imm=0x00 → second accept in the WB cycle of the first; reg1=0x08, `alu_a`=0x08 for the second command, `flag_c`=1 (sum 0x08 ≤ 0x80).
  - With `ALU_SEQ_CHAIN_EN`: `alu_cin`=0 for that command, reg3=0x08.
  - Chained follow-up add-with-carry dst=3 srca=3 imm=0x00 → `alu_cin`=1, reg3=0x09.
- pass=1 dst=0 srca=2 with op=011 → `alu_en`=0, reg0=reg2, `flag_c` unchanged.
- Assert `rst` during ISSUE of add dst=1 imm=0xFF → no write, reg1=0, `done` never pulses, `cmd_ready`=1 the cycle after reset.
